// File: rtl/accelerator_retention_vector.sv
// Retention vector psi(j) = prod_i (1 - f(i) * w_r(i,j)) in unsigned fixed point.
// Free gates are buffered first, then read weightings stream j-outer, i-inner.
module accelerator_retention_vector #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64,
   parameter int FRAC_SIZE    = 32,
   parameter int MAX_R        = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic                 F_IN_ENABLE,
   input  logic                 W_IN_ENABLE,
   output logic                 F_OUT_ENABLE,
   output logic                 W_OUT_ENABLE,
   output logic                 PSI_OUT_ENABLE,
   input  logic [DATA_SIZE-1:0] SIZE_R_IN,
   input  logic [DATA_SIZE-1:0] SIZE_N_IN,
   input  logic [DATA_SIZE-1:0] F_IN,
   input  logic [DATA_SIZE-1:0] W_IN,
   output logic [DATA_SIZE-1:0] PSI_OUT
);

   localparam int IDX_W = (MAX_R > 1) ? $clog2(MAX_R) : 1;
   localparam int DEPTH = 2 ** IDX_W;
   localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1) << FRAC_SIZE;
   localparam logic [DATA_SIZE-1:0] MAX_R_D = DATA_SIZE'(MAX_R);

   typedef enum logic [1:0] {
      IDLE,
      LOAD_F,
      LOAD_W,
      DONE
   } state_t;

   function automatic logic [DATA_SIZE-1:0] mul(
      input logic [DATA_SIZE-1:0] a,
      input logic [DATA_SIZE-1:0] b
   );
      logic [2*DATA_SIZE-1:0] p;
      p = ({{DATA_SIZE{1'b0}}, a} * {{DATA_SIZE{1'b0}}, b}) >> FRAC_SIZE;
      return p[DATA_SIZE-1:0];
   endfunction

   // gate products above ONE would wrap; clamp the term at zero instead
   function automatic logic [DATA_SIZE-1:0] term(
      input logic [DATA_SIZE-1:0] f,
      input logic [DATA_SIZE-1:0] w
   );
      logic [DATA_SIZE-1:0] m;
      m = mul(f, w);
      return (m > ONE) ? '0 : ONE - m;
   endfunction

   state_t                  state;
   logic [DATA_SIZE-1:0]    fbuf [DEPTH];
   logic [DATA_SIZE-1:0]    acc;
   logic [CONTROL_SIZE-1:0] i_q;
   logic [CONTROL_SIZE-1:0] j_q;
   logic [CONTROL_SIZE-1:0] r_q;
   logic [CONTROL_SIZE-1:0] n_q;

   logic [IDX_W-1:0]     idx;
   logic [DATA_SIZE-1:0] w_prod;
   logic [DATA_SIZE-1:0] r_clamp;
   logic                 r_last;
   logic                 n_last;
   logic                 f_acc;
   logic                 size_zero;

   always_comb begin
      idx       = i_q[IDX_W-1:0];
      w_prod    = mul(acc, term(fbuf[idx], W_IN));
      r_clamp   = (SIZE_R_IN > MAX_R_D) ? MAX_R_D : SIZE_R_IN;
      r_last    = (i_q == r_q - CONTROL_SIZE'(1));
      n_last    = (j_q == n_q - CONTROL_SIZE'(1));
      f_acc     = (state == LOAD_F) && F_IN_ENABLE;
      size_zero = (SIZE_R_IN == '0) || (SIZE_N_IN == '0);
   end

   always_ff @(posedge CLK) begin
      if (f_acc) fbuf[idx] <= F_IN;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= IDLE;
         READY          <= 1'b0;
         F_OUT_ENABLE   <= 1'b0;
         W_OUT_ENABLE   <= 1'b0;
         PSI_OUT_ENABLE <= 1'b0;
         PSI_OUT        <= '0;
         acc            <= ONE;
         i_q            <= '0;
         j_q            <= '0;
         r_q            <= '0;
         n_q            <= '0;
      end else begin
         PSI_OUT_ENABLE <= 1'b0;
         unique case (state)
            IDLE: begin
               if (START) begin
                  r_q <= CONTROL_SIZE'(r_clamp);
                  n_q <= CONTROL_SIZE'(SIZE_N_IN);
                  i_q <= '0;
                  j_q <= '0;
                  acc <= ONE;
                  if (size_zero) begin
                     state <= DONE;
                     READY <= 1'b1;
                  end else begin
                     state        <= LOAD_F;
                     F_OUT_ENABLE <= 1'b1;
                  end
               end
            end
            LOAD_F: begin
               if (F_IN_ENABLE) begin
                  if (r_last) begin
                     i_q          <= '0;
                     state        <= LOAD_W;
                     F_OUT_ENABLE <= 1'b0;
                     W_OUT_ENABLE <= 1'b1;
                  end else begin
                     i_q <= i_q + CONTROL_SIZE'(1);
                  end
               end
            end
            LOAD_W: begin
               if (W_IN_ENABLE) begin
                  if (r_last) begin
                     PSI_OUT        <= w_prod;
                     PSI_OUT_ENABLE <= 1'b1;
                     acc            <= ONE;
                     i_q            <= '0;
                     j_q            <= j_q + CONTROL_SIZE'(1);
                     if (n_last) begin
                        state        <= DONE;
                        W_OUT_ENABLE <= 1'b0;
                     end
                  end else begin
                     acc <= w_prod;
                     i_q <= i_q + CONTROL_SIZE'(1);
                  end
               end
            end
            DONE: begin
               // READY rises the cycle after the final psi pulse
               if (READY) begin
                  READY <= 1'b0;
                  state <= IDLE;
               end else begin
                  READY <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accelerator_retention_vector.sv
// Directed bench for accelerator_retention_vector.
// Expected psi values are queued at issue and popped by a monitor.
module tb_accelerator_retention_vector;

   localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
   localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        READY;
   logic        F_IN_ENABLE;
   logic        W_IN_ENABLE;
   logic        F_OUT_ENABLE;
   logic        W_OUT_ENABLE;
   logic        PSI_OUT_ENABLE;
   logic [63:0] SIZE_R_IN;
   logic [63:0] SIZE_N_IN;
   logic [63:0] F_IN;
   logic [63:0] W_IN;
   logic [63:0] PSI_OUT;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q [$];

   accelerator_retention_vector dut (
      .CLK            (CLK),
      .RST            (RST),
      .START          (START),
      .READY          (READY),
      .F_IN_ENABLE    (F_IN_ENABLE),
      .W_IN_ENABLE    (W_IN_ENABLE),
      .F_OUT_ENABLE   (F_OUT_ENABLE),
      .W_OUT_ENABLE   (W_OUT_ENABLE),
      .PSI_OUT_ENABLE (PSI_OUT_ENABLE),
      .SIZE_R_IN      (SIZE_R_IN),
      .SIZE_N_IN      (SIZE_N_IN),
      .F_IN           (F_IN),
      .W_IN           (W_IN),
      .PSI_OUT        (PSI_OUT)
   );

   always #5 CLK = ~CLK;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   always @(negedge CLK) begin
      if (!RST && PSI_OUT_ENABLE) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL psi_unexpected: got %h expected no pulse", PSI_OUT);
         end else begin
            chk("psi_value", PSI_OUT, exp_q.pop_front());
         end
      end
   end

   task automatic start(input logic [63:0] r, input logic [63:0] n);
      START = 1'b1;
      SIZE_R_IN = r;
      SIZE_N_IN = n;
      @(negedge CLK);
      START = 1'b0;
      SIZE_R_IN = 64'hDEAD;
      SIZE_N_IN = 64'hBEEF;
   endtask

   task automatic send_f(input logic [63:0] v);
      F_IN_ENABLE = 1'b1;
      F_IN = v;
      @(negedge CLK);
      F_IN_ENABLE = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] v, input logic pulse,
                         input logic [63:0] e);
      if (pulse) exp_q.push_back(e);
      W_IN_ENABLE = 1'b1;
      W_IN = v;
      @(negedge CLK);
      W_IN_ENABLE = 1'b0;
      chk("psi_en", {63'd0, PSI_OUT_ENABLE}, {63'd0, pulse});
   endtask

   task automatic expect_ready();
      chk("w_oe_drop", {63'd0, W_OUT_ENABLE}, 64'd0);
      chk("ready_early", {63'd0, READY}, 64'd0);
      @(negedge CLK);
      chk("ready", {63'd0, READY}, 64'd1);
      chk("psi_en_off", {63'd0, PSI_OUT_ENABLE}, 64'd0);
      @(negedge CLK);
      chk("ready_off", {63'd0, READY}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      RST = 1'b1;
      START = 1'b0;
      F_IN_ENABLE = 1'b0;
      W_IN_ENABLE = 1'b0;
      SIZE_R_IN = '0;
      SIZE_N_IN = '0;
      F_IN = '0;
      W_IN = '0;
      repeat (2) @(negedge CLK);
      chk("rst_ready", {63'd0, READY}, 64'd0);
      chk("rst_f_oe", {63'd0, F_OUT_ENABLE}, 64'd0);
      chk("rst_w_oe", {63'd0, W_OUT_ENABLE}, 64'd0);
      chk("rst_psi_en", {63'd0, PSI_OUT_ENABLE}, 64'd0);
      chk("rst_psi", PSI_OUT, 64'd0);
      RST = 1'b0;
      @(negedge CLK);

      // stray enables in IDLE do nothing
      F_IN_ENABLE = 1'b1;
      W_IN_ENABLE = 1'b1;
      @(negedge CLK);
      F_IN_ENABLE = 1'b0;
      W_IN_ENABLE = 1'b0;
      chk("idle_f_oe", {63'd0, F_OUT_ENABLE}, 64'd0);
      chk("idle_w_oe", {63'd0, W_OUT_ENABLE}, 64'd0);

      // R=1 N=1: 1 - 0.25
      start(1, 1);
      chk("s1_f_oe", {63'd0, F_OUT_ENABLE}, 64'd1);
      send_f(HALF);
      chk("s1_f_oe_off", {63'd0, F_OUT_ENABLE}, 64'd0);
      chk("s1_w_oe", {63'd0, W_OUT_ENABLE}, 64'd1);
      send_w(HALF, 1'b1, 64'hC000_0000);
      expect_ready();

      // R=2 N=2, stray W enable during LOAD_F must be ignored
      start(2, 2);
      W_IN_ENABLE = 1'b1;
      W_IN = 64'hFFFF_FFFF_FFFF_FFFF;
      send_f(HALF);
      W_IN_ENABLE = 1'b0;
      send_f(HALF);
      send_w(HALF, 1'b0, 64'd0);
      send_w(HALF, 1'b1, 64'h9000_0000);
      send_w(HALF, 1'b0, 64'd0);
      send_w(HALF, 1'b1, 64'h9000_0000);
      expect_ready();
      chk("psi_hold", PSI_OUT, 64'h9000_0000);

      // R=1 N=3 back-to-back pulses
      start(1, 3);
      send_f(ONE);
      send_w(64'd0, 1'b1, ONE);
      send_w(ONE, 1'b1, 64'd0);
      send_w(64'h4000_0000, 1'b1, 64'hC000_0000);
      expect_ready();

      // saturating term
      start(1, 1);
      send_f(64'h2_0000_0000);
      send_w(ONE, 1'b1, 64'd0);
      expect_ready();

      // R above MAX_R clamps to 8: 0.75^8
      start(9, 1);
      for (int k = 0; k < 8; k++) send_f(HALF);
      chk("clamp_f_oe_off", {63'd0, F_OUT_ENABLE}, 64'd0);
      chk("clamp_w_oe", {63'd0, W_OUT_ENABLE}, 64'd1);
      for (int k = 0; k < 7; k++) send_w(HALF, 1'b0, 64'd0);
      send_w(HALF, 1'b1, 64'h19A1_0000);
      expect_ready();

      // N=0 goes straight to DONE
      start(1, 0);
      chk("n0_ready", {63'd0, READY}, 64'd1);
      chk("n0_f_oe", {63'd0, F_OUT_ENABLE}, 64'd0);
      chk("n0_w_oe", {63'd0, W_OUT_ENABLE}, 64'd0);
      chk("n0_psi_en", {63'd0, PSI_OUT_ENABLE}, 64'd0);
      @(negedge CLK);
      chk("n0_ready_off", {63'd0, READY}, 64'd0);

      // R=0 likewise
      start(0, 4);
      chk("r0_ready", {63'd0, READY}, 64'd1);
      chk("r0_f_oe", {63'd0, F_OUT_ENABLE}, 64'd0);
      @(negedge CLK);

      // reset after one of four W words
      start(2, 2);
      send_f(HALF);
      send_f(HALF);
      send_w(HALF, 1'b0, 64'd0);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("mid_rst_ready", {63'd0, READY}, 64'd0);
      chk("mid_rst_f_oe", {63'd0, F_OUT_ENABLE}, 64'd0);
      chk("mid_rst_w_oe", {63'd0, W_OUT_ENABLE}, 64'd0);
      chk("mid_rst_psi_en", {63'd0, PSI_OUT_ENABLE}, 64'd0);
      chk("mid_rst_psi", PSI_OUT, 64'd0);
      repeat (3) @(negedge CLK);
      chk("mid_rst_idle_ready", {63'd0, READY}, 64'd0);
      start(1, 1);
      send_f(HALF);
      send_w(HALF, 1'b1, 64'hC000_0000);
      expect_ready();

      repeat (2) @(negedge CLK);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
